audio_gain_mac_multi: RTL

// Multi-channel fixed-point gain stage for the audio datapath.
// - Applies a per-channel programmable gain to each sample frame.
// - Ramps each gain toward its target to avoid zipper noise.
// - Saturates results to DATA_W bits; they never wrap.
// - Time-multiplexes one registered multiplier over NUM_CH channels. Sits between the I2S receiver and the filter/EQ chain.
//

---
 rtl/audio_dsp_pkg.sv | 32 +++
 rtl/gain_sat_mul.sv | 33 +++
 rtl/audio_gain_mac_multi.sv | 131 +++++++++++++
 3 files changed

// File: rtl/audio_dsp_pkg.sv
// Shared audio DSP types and fixed-point helpers.
// Pure combinational helpers (no latency, no flow control).
package audio_dsp_pkg;

    typedef enum logic [1:0] {IDLE, MUL, SAT, DONE} gain_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_FRAC_W = 14;

    function automatic int unity(input int frac_w);
        return 1 << frac_w;
    endfunction

    // Arithmetic shift (truncation toward -inf) then clamp to a signed data_w range.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] product,
                                                     input int frac_w, input int data_w);
        logic signed [63:0] y, maxv, minv;
        y    = product >>> frac_w;
        maxv = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (data_w - 1));
        if (y > maxv)      return maxv;
        else if (y < minv) return minv;
        return y;
    endfunction

    function automatic logic sat_clip(input logic signed [63:0] product,
                                      input int frac_w, input int data_w);
        return sat_shift(product, frac_w, data_w) != (product >>> frac_w);
    endfunction

endpackage

// File: rtl/gain_sat_mul.sv
// Registered signed sample x gain multiply (1 cycle) with combinational shift/saturate/clip.
// No flow control: product loads whenever i_en is high.
module gain_sat_mul
    import audio_dsp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic signed [COEF_W-1:0] i_gain,
    output logic signed [DATA_W-1:0] o_y,
    output logic                     o_clip
);
    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0] r_product;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_product <= '0;
        end else if (i_en) begin
            r_product <= PW'(i_sample) * PW'(i_gain);
        end
    end

    assign o_y    = DATA_W'(sat_shift(64'(r_product), FRAC_W, DATA_W));
    assign o_clip = sat_clip(64'(r_product), FRAC_W, DATA_W);

endmodule

// File: rtl/audio_gain_mac_multi.sv
// Multi-channel ramped gain stage; one shared multiplier, out_valid 2*NUM_CH+1 cycles after sample_valid.
// No backpressure: a frame arriving while busy is dropped and flagged in sticky overrun.
module audio_gain_mac_multi
    import audio_dsp_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int FRAC_W    = DEF_FRAC_W,
    parameter int NUM_CH    = 2,
    parameter int RAMP_STEP = 'h0040,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_audio_in,
    input  logic                     i_gain_wr,
    input  logic [CH_W-1:0]          i_gain_ch,
    input  logic signed [COEF_W-1:0] i_gain_val,
    output logic [NUM_CH*DATA_W-1:0] o_audio_out,
    output logic                     o_out_valid,
    output logic                     o_busy,
    output logic [NUM_CH-1:0]        o_clip,
    output logic                     o_overrun
);
    localparam logic signed [COEF_W-1:0] UNITY  = COEF_W'(unity(FRAC_W));
    localparam logic signed [COEF_W:0]   STEP   = (COEF_W + 1)'(RAMP_STEP);
    localparam logic signed [COEF_W-1:0] STEP_C = COEF_W'(RAMP_STEP);
    localparam logic [CH_W-1:0]          LAST   = CH_W'(NUM_CH - 1);

    gain_state_t                r_state, w_state_nxt;
    logic [CH_W-1:0]            r_ch;
    logic [NUM_CH*DATA_W-1:0]   r_frame;
    logic [NUM_CH*DATA_W-1:0]   r_out;
    logic [NUM_CH-1:0]          r_clip;
    logic                       r_overrun;
    logic signed [COEF_W-1:0]   r_target [NUM_CH];
    logic signed [COEF_W-1:0]   r_cur    [NUM_CH];

    logic                       w_mul_en;
    logic signed [DATA_W-1:0]   w_sample;
    logic signed [DATA_W-1:0]   w_y;
    logic                       w_clip;
    logic signed [COEF_W-1:0]   w_tgt, w_cur, w_cur_nxt;
    logic signed [COEF_W:0]     w_d;

    assign w_sample = r_frame[32'(r_ch)*DATA_W +: DATA_W];

    gain_sat_mul #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_mul_en),
        .i_sample (w_sample),
        .i_gain   (r_cur[r_ch]),
        .o_y      (w_y),
        .o_clip   (w_clip)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mul_en    = 1'b0;
        o_busy      = (r_state != IDLE);
        o_out_valid = 1'b0;
        case (r_state)
            IDLE: if (i_sample_valid) w_state_nxt = MUL;
            MUL: begin
                w_mul_en    = 1'b1;
                w_state_nxt = SAT;
            end
            SAT:  w_state_nxt = (r_ch == LAST) ? DONE : MUL;
            DONE: begin
                o_out_valid = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ramp reads the target before any same-cycle write lands, so a concurrent gain_wr waits a frame.
    always_comb begin
        w_tgt     = r_target[r_ch];
        w_cur     = r_cur[r_ch];
        w_d       = {w_tgt[COEF_W-1], w_tgt} - {w_cur[COEF_W-1], w_cur};
        w_cur_nxt = w_tgt;
        if (RAMP_STEP != 0 && (w_d > STEP || w_d < -STEP)) begin
            w_cur_nxt = w_d[COEF_W] ? (w_cur - STEP_C) : (w_cur + STEP_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_frame   <= '0;
            r_out     <= '0;
            r_clip    <= '0;
            r_overrun <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_target[k] <= UNITY;
                r_cur[k]    <= UNITY;
            end
        end else begin
            r_state <= w_state_nxt;
            if (i_sample_valid && r_state == IDLE) begin
                r_frame <= i_audio_in;
                r_ch    <= '0;
            end
            if (i_sample_valid && r_state != IDLE) begin
                r_overrun <= 1'b1;
            end
            if (i_gain_wr && 32'(i_gain_ch) < NUM_CH) begin
                r_target[i_gain_ch] <= i_gain_val;
            end
            if (r_state == SAT) begin
                r_out[32'(r_ch)*DATA_W +: DATA_W] <= w_y;
                r_clip[r_ch]                      <= w_clip;
                r_cur[r_ch]                       <= w_cur_nxt;
                if (r_ch != LAST) r_ch <= r_ch + 1'b1;
            end
        end
    end

    assign o_audio_out = r_out;
    assign o_clip      = r_clip;
    assign o_overrun   = r_overrun;

endmodule
